// File: rtl/chi_line_responder_if.sv
// ---------------------------------------------------------------------------
// chi_line_responder_if
// Request and response channels between a dcache MSHR refill requester and
// the chi_line_responder.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid & ready are both 1. Once valid is raised, the source holds valid
// and its payload stable until that edge. Ready may change freely and does
// not depend on valid.
//
//   req_valid / req_ready       line-read request channel (requester -> responder)
//   req_paddr                   physical address, bits [5:0] ignored
//   req_mshrid                  requesting MSHR id
//   resp_valid / resp_ready     refill response channel (responder -> requester)
//   resp_data                   512-bit line, beat i in [64*i+63:64*i]
//   resp_mshrid                 id of the request being answered
//
// Modports: master = requester side, slave = responder side.
// ---------------------------------------------------------------------------
interface chi_line_responder_if #(
   parameter int PADDR_W = 40,
   parameter int MSHR_W  = 4
);
   logic               req_valid;
   logic               req_ready;
   logic [PADDR_W-1:0] req_paddr;
   logic [MSHR_W-1:0]  req_mshrid;
   logic               resp_valid;
   logic               resp_ready;
   logic [511:0]       resp_data;
   logic [MSHR_W-1:0]  resp_mshrid;

   modport master (
      output req_valid, req_paddr, req_mshrid, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_mshrid
   );

   modport slave (
      input  req_valid, req_paddr, req_mshrid, resp_ready,
      output req_ready, resp_valid, resp_data, resp_mshrid
   );
endinterface

// File: rtl/chi_line_responder.sv
// ---------------------------------------------------------------------------
// chi_line_responder
// L2/MEM-side model for dcache MSHR line fills. Line-read requests are queued
// in order; each line is fetched as eight 64-bit beats from a backing
// SRAM-style port (data returns one cycle after the strobe), assembled into a
// 512-bit buffer and returned with its MSHR id. One line in flight at a time.
//
// Ports:
//   clock, reset_n   clock; asynchronous active-low reset
//   bus              request / response channels (slave modport)
//   mem_rd_en        backing read strobe, one beat per cycle
//   mem_rd_addr      beat address {line addr, beat[2:0], 3'b000}; 0 when idle
//   mem_rd_data      backing read data, valid one cycle after mem_rd_en
//   state_dbg        current FSM state
// ---------------------------------------------------------------------------
module chi_line_responder #(
   parameter int REQ_DEPTH = 4,
   parameter int EXTRA_LAT = 0,
   parameter int PADDR_W   = 40,
   parameter int MSHR_W    = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   chi_line_responder_if.slave  bus,
   output logic                 mem_rd_en,
   output logic [PADDR_W-1:0]   mem_rd_addr,
   input  logic [63:0]          mem_rd_data,
   output logic [2:0]           state_dbg
);
   localparam int PTR_W  = $clog2(REQ_DEPTH);
   localparam int LINE_W = PADDR_W - 6;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(REQ_DEPTH);
   localparam logic [7:0]     LAT_INIT = 8'(EXTRA_LAT);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LAT   = 3'd1;
   localparam logic [2:0] ST_FETCH = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   logic [LINE_W-1:0] q_line [REQ_DEPTH];
   logic [MSHR_W-1:0] q_id   [REQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;

   logic [2:0]        state;
   logic [LINE_W-1:0] cur_line;
   logic [MSHR_W-1:0] cur_mshrid;
   logic [2:0]        beat;
   logic [7:0]        lat_cnt;
   logic [7:0][63:0]  line_buf;

   logic push, pop;
   logic unused_low;

   // Line offset bits are dropped on entry to the queue.
   assign unused_low = ^bus.req_paddr[5:0];

   // No bypass: a full queue refuses even when a pop happens this cycle.
   assign bus.req_ready = (count != FULL_CNT);
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = (state == ST_IDLE) && (count != '0);

   assign mem_rd_en       = (state == ST_FETCH);
   assign mem_rd_addr     = mem_rd_en ? {cur_line, beat, 3'b000} : '0;
   assign bus.resp_valid  = (state == ST_RESP);
   assign bus.resp_data   = line_buf;
   assign bus.resp_mshrid = cur_mshrid;
   assign state_dbg       = state;

   // Queue storage carries no reset; only pointers and count define contents.
   always_ff @(posedge clock) begin
      if (push) begin
         q_line[wr_ptr] <= bus.req_paddr[PADDR_W-1:6];
         q_id[wr_ptr]   <= bus.req_mshrid;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         state      <= ST_IDLE;
         cur_line   <= '0;
         cur_mshrid <= '0;
         beat       <= '0;
         lat_cnt    <= '0;
         line_buf   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  cur_line   <= q_line[rd_ptr];
                  cur_mshrid <= q_id[rd_ptr];
                  beat       <= '0;
                  lat_cnt    <= LAT_INIT;
                  state      <= (EXTRA_LAT > 0) ? ST_LAT : ST_FETCH;
               end
            end
            ST_LAT: begin
               // Leaves on the cycle the counter reads 1: EXTRA_LAT cycles here.
               if (lat_cnt <= 8'd1) state   <= ST_FETCH;
               else                 lat_cnt <= lat_cnt - 8'd1;
            end
            ST_FETCH: begin
               // Data for the previous beat arrives while the next is issued.
               if (beat != 3'd0) line_buf[beat - 3'd1] <= mem_rd_data;
               beat <= beat + 3'd1;
               if (beat == 3'd7) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               line_buf[7] <= mem_rd_data;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_chi_line_responder.sv
// ---------------------------------------------------------------------------
// tb_chi_line_responder
// Two responders side by side: lane 0 with EXTRA_LAT=0, lane 1 with
// EXTRA_LAT=3. A backing memory returns a fixed address-derived pattern one
// cycle after each strobe (random junk otherwise). Expected lines are built
// from the request address and pushed into per-lane queues on acceptance; a
// monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_chi_line_responder;
   localparam int PADDR_W = 40;
   localparam int MSHR_W  = 4;
   localparam int DEPTH   = 4;
   localparam int W       = MSHR_W + 512;

   // ---------------- clock / reset ----------------
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   chi_line_responder_if #(.PADDR_W(PADDR_W), .MSHR_W(MSHR_W)) if0 ();
   chi_line_responder_if #(.PADDR_W(PADDR_W), .MSHR_W(MSHR_W)) if1 ();

   logic               mem_en0, mem_en1;
   logic [PADDR_W-1:0] mem_addr0, mem_addr1;
   logic [63:0]        mem_data0, mem_data1;
   logic [2:0]         dbg0, dbg1;

   chi_line_responder #(.REQ_DEPTH(DEPTH), .EXTRA_LAT(0), .PADDR_W(PADDR_W), .MSHR_W(MSHR_W)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(if0.slave),
      .mem_rd_en(mem_en0), .mem_rd_addr(mem_addr0), .mem_rd_data(mem_data0), .state_dbg(dbg0));
   chi_line_responder #(.REQ_DEPTH(DEPTH), .EXTRA_LAT(3), .PADDR_W(PADDR_W), .MSHR_W(MSHR_W)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(if1.slave),
      .mem_rd_en(mem_en1), .mem_rd_addr(mem_addr1), .mem_rd_data(mem_data1), .state_dbg(dbg1));

   // ---------------- memory and reference model ----------------
   function automatic logic [63:0] pat(input logic [PADDR_W-1:0] a);
      return {~a[31:0], a[31:0] ^ 32'h1234_5678 ^ {24'h0, a[39:32]}};
   endfunction

   function automatic logic [W-1:0] expect_line(input logic [PADDR_W-1:0] pa, input logic [MSHR_W-1:0] id);
      logic [PADDR_W-1:0] base;
      logic [511:0]       d;
      base = pa & ~PADDR_W'(63);
      for (int i = 0; i < 8; i++) d[64*i +: 64] = pat(base + PADDR_W'(8*i));
      return {id, d};
   endfunction

   always @(posedge clock) begin
      mem_data0 <= mem_en0 ? pat(mem_addr0) : {$urandom, $urandom};
      mem_data1 <= mem_en1 ? pat(mem_addr1) : {$urandom, $urandom};
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   int           hs_q0[$];
   int           hs_q1[$];
   int           n_cmp  = 0;
   int           n_fail = 0;
   bit           stall[2];
   logic [W-1:0] stall_val[2];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic mon_step(input int ln);
      logic         rv, rr, men;
      logic [W-1:0] act, e;
      rv  = (ln == 0) ? if0.resp_valid : if1.resp_valid;
      rr  = (ln == 0) ? if0.resp_ready : if1.resp_ready;
      men = (ln == 0) ? mem_en0 : mem_en1;
      act = (ln == 0) ? {if0.resp_mshrid, if0.resp_data} : {if1.resp_mshrid, if1.resp_data};
      if (!reset_n) begin
         stall[ln] = 1'b0;
         return;
      end
      if (stall[ln]) begin
         chk("resp_hold_valid", W'(rv), W'(1));
         chk("resp_hold_payload", act, stall_val[ln]);
      end
      if (rv) chk("no_rd_during_resp", W'(men), W'(0));
      if (rv && rr) begin
         stall[ln] = 1'b0;
         if (ln == 0) hs_q0.push_back(cyc); else hs_q1.push_back(cyc);
         n_cmp++;
         if (((ln == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected lane%0d: got %0h want none", ln, act);
         end else begin
            e = (ln == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            n_cmp--;
            chk($sformatf("resp_line lane%0d", ln), act, e);
         end
      end else if (rv) begin
         stall[ln]     = 1'b1;
         stall_val[ln] = act;
      end else begin
         stall[ln] = 1'b0;
      end
   endtask

   initial forever begin
      @(negedge clock);
      mon_step(0);
      mon_step(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ready(input int ln, input logic v);
      if (ln == 0) if0.resp_ready = v; else if1.resp_ready = v;
   endtask

   // Entered and left at posedge+1; consecutive calls issue back-to-back.
   task automatic send(input int ln, input logic [PADDR_W-1:0] pa, input logic [MSHR_W-1:0] id, output int acc);
      bit done = 0;
      acc = -1;
      if (ln == 0) begin if0.req_valid = 1; if0.req_paddr = pa; if0.req_mshrid = id; end
      else         begin if1.req_valid = 1; if1.req_paddr = pa; if1.req_mshrid = id; end
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clock);
         if ((ln == 0) ? if0.req_ready : if1.req_ready) begin
            done = 1;
            acc  = cyc;
            if (ln == 0) exp_q0.push_back(expect_line(pa, id));
            else         exp_q1.push_back(expect_line(pa, id));
         end
         tick();
      end
      if (ln == 0) if0.req_valid = 0; else if1.req_valid = 0;
      chk("send_accepted", W'(done), W'(1));
   endtask

   task automatic wait_empty(input int ln, input int bound);
      int t = 0;
      while (((ln == 0) ? exp_q0.size() : exp_q1.size()) != 0 && t < bound) begin
         tick();
         t++;
      end
      chk("drain_in_time", W'(t < bound), W'(1));
   endtask

   // Follows one request from acceptance cycle t0 to the rise of resp_valid.
   task automatic observe(input int ln, input logic [PADDR_W-1:0] pa, input int t0, input int lat);
      logic [PADDR_W-1:0] base, addr;
      int beats = 0, rv_cyc = -1;
      base = pa & ~PADDR_W'(63);
      for (int k = 0; k < 60 && rv_cyc < 0; k++) begin
         @(negedge clock);
         addr = (ln == 0) ? mem_addr0 : mem_addr1;
         if ((ln == 0) ? mem_en0 : mem_en1) begin
            chk("beat_addr", W'(addr), W'(base + PADDR_W'(8*beats)));
            chk("beat_cycle", W'(cyc), W'(t0 + 2 + lat + beats));
            beats++;
         end
         if ((ln == 0) ? if0.resp_valid : if1.resp_valid) rv_cyc = cyc;
      end
      chk("beat_count", W'(beats), W'(8));
      chk("resp_valid_cycle", W'(rv_cyc), W'(t0 + 11 + lat));
      tick();
   endtask

   task automatic throughput(input int ln, input int period);
      int a;
      if (ln == 0) hs_q0.delete(); else hs_q1.delete();
      set_ready(ln, 1);
      for (int i = 0; i < 3; i++) send(ln, PADDR_W'({$urandom, $urandom}), MSHR_W'(i + 8), a);
      wait_empty(ln, 200);
      for (int i = 1; i < 3; i++)
         if (ln == 0) chk("line_period", W'(hs_q0[i] - hs_q0[i-1]), W'(period));
         else         chk("line_period", W'(hs_q1[i] - hs_q1[i-1]), W'(period));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", W'({if1.req_ready, if0.req_ready}), W'(2'b11));
      chk("rst_mem_rd_en", W'({mem_en1, mem_en0}), W'(0));
      chk("rst_mem_rd_addr", W'({mem_addr1, mem_addr0}), W'(0));
      chk("rst_resp_valid", W'({if1.resp_valid, if0.resp_valid}), W'(0));
      chk("rst_resp0", {if0.resp_mshrid, if0.resp_data}, W'(0));
      chk("rst_resp1", {if1.resp_mshrid, if1.resp_data}, W'(0));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int t0, a, hs_cyc;
      logic [PADDR_W-1:0] pa;
      bit wrap_done;
      if0.req_valid = 0; if0.req_paddr = '0; if0.req_mshrid = '0; if0.resp_ready = 0;
      if1.req_valid = 0; if1.req_paddr = '0; if1.req_mshrid = '0; if1.resp_ready = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_reset_outputs();
      tick();
      reset_n = 1;
      tick();

      // Single line, both line-aligned and offset addresses.
      set_ready(0, 1);
      send(0, 40'h1040, 4'd2, t0);
      observe(0, 40'h1040, t0, 0);
      wait_empty(0, 50);
      send(0, 40'h1047, 4'd2, t0);
      observe(0, 40'h1047, t0, 0);
      wait_empty(0, 50);

      // Fill the queue under backpressure.
      set_ready(0, 0);
      send(0, 40'h2000, 4'd0, t0);
      for (int i = 1; i < 5; i++) begin
         send(0, PADDR_W'(40'h2000 + 64*i), MSHR_W'(i), a);
         chk("fill_accept_cycle", W'(a), W'(t0 + i));
      end
      @(negedge clock);
      chk("fill_full_ready", W'(if0.req_ready), W'(0));
      tick();
      fork
         send(0, 40'h2140, 4'd5, a);
         begin
            repeat (8) tick();
            @(negedge clock);
            chk("fill_still_held", W'(if0.req_ready), W'(0));
            tick();
            set_ready(0, 1);
         end
      join
      wait_empty(0, 200);

      // Response stall of 20 cycles, with the queue accepting meanwhile.
      set_ready(0, 0);
      send(0, 40'h3000, 4'd9, t0);
      for (int k = 0; k < 40 && !if0.resp_valid; k++) @(negedge clock);
      chk("stall_resp_rise", W'(if0.resp_valid), W'(1));
      tick();
      send(0, 40'h3040, 4'd10, a);
      send(0, 40'h3080, 4'd11, a);
      repeat (17) tick();
      set_ready(0, 1);
      @(negedge clock);
      hs_cyc = cyc;
      #1;
      chk("stall_hs_first_ready", W'(hs_q0[$]), W'(hs_cyc));
      tick();
      set_ready(0, 0);
      @(negedge clock);
      chk("stall_valid_drops", W'(if0.resp_valid), W'(0));
      tick();
      set_ready(0, 1);
      wait_empty(0, 100);

      // Extra latency lane: timing and period.
      set_ready(1, 1);
      send(1, 40'hABC0, 4'd3, t0);
      observe(1, 40'hABC0, t0, 3);
      wait_empty(1, 50);
      throughput(1, 14);
      throughput(0, 11);

      // Reset during FETCH with two more requests queued.
      set_ready(0, 1);
      send(0, 40'h5000, 4'd1, a);
      send(0, 40'h5040, 4'd2, a);
      send(0, 40'h5080, 4'd3, a);
      for (int k = 0; k < 40 && !(mem_en0 && mem_addr0[5:3] == 3'd4); k++) @(negedge clock);
      chk("rst_saw_beat4", W'(mem_en0 && mem_addr0[5:3] == 3'd4), W'(1));
      @(posedge clock);
      #1;
      reset_n = 0;
      exp_q0.delete();
      #1;
      chk_reset_outputs();
      repeat (2) tick();
      reset_n = 1;
      tick();
      send(0, 40'h7700, 4'd7, t0);
      observe(0, 40'h7700, t0, 0);
      wait_empty(0, 50);
      repeat (40) tick();

      // Pointer wrap with random backpressure.
      wrap_done = 0;
      fork
         begin
            for (int i = 0; i < 3*DEPTH + 1; i++) begin
               pa = PADDR_W'({$urandom, $urandom});
               send(0, pa, MSHR_W'($urandom_range(0, 15)), a);
               repeat ($urandom_range(0, 2)) tick();
            end
            wrap_done = 1;
         end
         begin
            while (!wrap_done) begin
               tick();
               if0.resp_ready = 1'($urandom_range(0, 1));
            end
            set_ready(0, 1);
         end
      join
      wait_empty(0, 400);
      wait_empty(1, 50);
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/chi_line_responder.md
# chi_line_responder

Downstream responder for dcache MSHR line-fill requests; it models the L2/MEM side of the MSHR-to-CHI refill path. It accepts line-read requests (paddr plus MSHR id) into a small in-order queue and fetches each 64-byte line as eight 64-bit beats from a backing SRAM-style read port. It returns the assembled 512-bit line with its MSHR id on a valid/ready response channel, one line at a time, in request order.

## Interface
- REQ_DEPTH, 4, request queue depth; must be a power of 2 and at least 2.
- EXTRA_LAT, 0, idle cycles inserted between dequeue and the first beat read (0..255).
- clock  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  line-read request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_paddr  in  `PADDR_RANGE  physical address; bits [5:0] are ignored (line-aligned).
- req_mshrid  in  `MSHR_NUM_LOG  requesting MSHR entry id.
- mem_rd_en  out  1  backing read strobe, one beat per cycle.
- mem_rd_addr  out  `PADDR_RANGE  beat address = {line addr, beat[2:0], 3'b000}.
- mem_rd_data  in  64  read data, valid exactly 1 cycle after mem_rd_en.
- resp_valid  out  1  refill response valid.
- resp_ready  in  1  response consumer ready.
- resp_data  out  512  line data; beat i occupies [64*i+63:64*i].
- resp_mshrid  out  `MSHR_NUM_LOG  id of the request being answered.

## Operation
- Queue: circular FIFO of {line paddr, mshrid}. Read/write pointers are log2(REQ_DEPTH) bits and wrap naturally. The count is log2(REQ_DEPTH)+1 bits.
- req_ready = (count != REQ_DEPTH). There is no bypass: when full, req_ready stays 0 even if a pop occurs in the same cycle. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, LAT, FETCH, DRAIN, RESP.
  - IDLE: if count != 0, pop the head into cur_paddr/cur_mshrid and clear the beat counter. Go to LAT when EXTRA_LAT > 0; otherwise go to FETCH.
  - LAT: an 8-bit down-counter is loaded with EXTRA_LAT on entry. Go to FETCH on the cycle the counter reaches 1 (total EXTRA_LAT cycles in LAT).
  - FETCH: assert mem_rd_en with beat = 0..7 on 8 consecutive cycles. After beat 7 is issued, go to DRAIN.
  - DRAIN: capture beat 7. Go to RESP.
  - RESP: resp_valid = 1. On resp_valid & resp_ready go to IDLE; the next pop can occur in the following IDLE cycle.
- Beat capture: the data returned for beat k is written into line buffer slice k on the cycle after beat k is issued (captures happen in FETCH and DRAIN).
- resp_data and resp_mshrid hold stable while resp_valid is high and resp_ready is low.
- Responses leave strictly in acceptance order. Only one line is in flight at a time.
- mem_rd_en is 0 in every state other than FETCH.

## Timing
- Reset values: req_ready = 1, mem_rd_en = 0, mem_rd_addr = 0, resp_valid = 0, resp_data = 0, resp_mshrid = 0. State = IDLE, queue empty.
- Latency with an empty queue and the FSM in IDLE, request accepted at cycle T:
  - pop at T+1;
  - LAT occupies T+2 .. T+1+EXTRA_LAT;
  - FETCH occupies 8 cycles;
  - DRAIN occupies 1 cycle;
  - resp_valid first seen at T+11+EXTRA_LAT.
- Throughput: one line per 11+EXTRA_LAT cycles when resp_ready is held at 1.
- Reset asserted mid-operation: state, counters and queue clear immediately. A mem_rd_data return for an issued beat is discarded. No response is produced for queued or in-flight requests.
- Response backpressure: while resp_valid is stalled by resp_ready = 0, the queue keeps accepting requests until full.

## Test plan
- Single request, EXTRA_LAT=0: paddr 0x1040, mshrid 2, accepted at T.
  - Required: mem_rd_addr sequence 0x1040, 0x1048, …, 0x1078 on cycles T+2..T+9.
  - Required: resp_valid at T+11 with resp_mshrid = 2 and resp_data beat i = the memory pattern at 0x1040+8i.
  - Stimulus detail: req_paddr low bits set to 0x1047 must produce identical behaviour.
- Fill the queue:
  - Stimulus: 6 back-to-back requests (ids 0..5) with resp_ready = 0 and REQ_DEPTH = 4.
  - Required: the first pops at T+1; req_ready drops after 4 more are queued (5 accepted in total); the 6th is held.
  - Required: after resp_ready is raised, responses emerge with ids 0..5 in order.
- Response backpressure:
  - Stimulus: hold resp_ready = 0 for 20 cycles after resp_valid rises.
  - Required: resp_data and resp_mshrid stay stable; no mem_rd_en during the stall.
  - Required: handshake completes on the first cycle resp_ready = 1, and resp_valid drops the next cycle.
- EXTRA_LAT = 3:
  - Required: first mem_rd_en at T+5 and resp_valid at T+14.
  - Required: back-to-back requests with resp_ready = 1 complete every 14 cycles.
- Reset mid-FETCH:
  - Stimulus: assert reset_n = 0 after beat 4 is issued, with 2 requests queued.
  - Required: all outputs return to reset values immediately.
  - Required: after release, a new request with id 7 gets a correct response and no stale response appears.
- Pointer wrap: 3×REQ_DEPTH+1 sequential requests with random resp_ready.
  - Required: every response matches its request's data and id, in order.
